pedestrian_signal: RTL and testbench

- Downstream consumer of the intersection's 3-bit vehicle light code.
- Latches a pedestrian push-button request and grants a WALK interval only while vehicles are held at RED.
- Follows WALK with a flashing DON'T-WALK clearance interval, then returns to steady DON'T-WALK.
- Drives the crossing lamp outputs and reports request/conflict status to the supervisory logic.

---
 rtl/pedestrian_signal_if.sv | 36 +++
 rtl/pedestrian_signal.sv | 140 ++++++++++++++
 tb/tb_pedestrian_signal.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pedestrian_signal_if.sv
// Crossing signal bundle: vehicle light code and push-button in, lamp/status outputs back.
// The design side uses the slave modport; the driver/monitor side uses master.
interface pedestrian_signal_if #(
  parameter int CNT_W = 4
);
  logic [2:0]       lights;
  logic             ped_req;
  logic             walk;
  logic             dont_walk;
  logic             req_pending;
  logic             ped_ack;
  logic [CNT_W-1:0] count;
  logic             conflict;

  modport master (
    output lights,
    output ped_req,
    input  walk,
    input  dont_walk,
    input  req_pending,
    input  ped_ack,
    input  count,
    input  conflict
  );

  modport slave (
    input  lights,
    input  ped_req,
    output walk,
    output dont_walk,
    output req_pending,
    output ped_ack,
    output count,
    output conflict
  );
endinterface

// File: rtl/pedestrian_signal.sv
// Pedestrian crossing controller: latches button requests and grants WALK/flashing CLEAR while vehicles hold RED.
// Optional feature macro PEDESTRIAN_SIGNAL_CONFLICT_EN aborts to IDLE and sets sticky conflict if lights leave RED.
module pedestrian_signal #(
  parameter int WALK_CYCLES  = 8,
  parameter int CLEAR_CYCLES = 6,
  parameter int CNT_W        = 4
) (
  input logic                clk,
  input logic                reset_n,
  pedestrian_signal_if.slave bus
);

  localparam logic [2:0]       LIGHT_RED  = 3'b100;
  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_WALK  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_req;
  logic             r_walk;
  logic             r_dontWalk;
  logic             r_ack;

  logic             w_isRed;
  logic             w_countZero;
  logic [CNT_W-1:0] w_countDec;

  assign w_isRed     = (bus.lights == LIGHT_RED);
  assign w_countZero = (r_count == '0);
  assign w_countDec  = r_count - CNT_W'(1);

`ifdef PEDESTRIAN_SIGNAL_CONFLICT_EN
  logic r_conflict;
  logic w_abort;

  assign w_abort = ((r_state == S_WALK) || (r_state == S_CLEAR)) && !w_isRed;
`endif

  // Lamp outputs are registered alongside the state so they never see a combinational input path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_req      <= 1'b0;
      r_walk     <= 1'b0;
      r_dontWalk <= 1'b1;
      r_ack      <= 1'b0;
`ifdef PEDESTRIAN_SIGNAL_CONFLICT_EN
      r_conflict <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
`ifdef PEDESTRIAN_SIGNAL_CONFLICT_EN
      if (w_abort) begin
        r_state    <= S_IDLE;
        r_count    <= '0;
        r_req      <= 1'b0;
        r_walk     <= 1'b0;
        r_dontWalk <= 1'b1;
        r_conflict <= 1'b1;
      end else
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.ped_req) begin
            r_state <= S_ARMED;
            r_req   <= 1'b1;
          end
        end
        // Entering WALK consumes the latch; a button press in this same cycle is absorbed by the grant.
        S_ARMED: begin
          if (w_isRed) begin
            r_state    <= S_WALK;
            r_req      <= 1'b0;
            r_count    <= WALK_LOAD;
            r_walk     <= 1'b1;
            r_dontWalk <= 1'b0;
            r_ack      <= 1'b1;
          end
        end
        S_WALK: begin
          if (bus.ped_req) begin
            r_req <= 1'b1;
          end
          if (w_countZero) begin
            r_state    <= S_CLEAR;
            r_count    <= CLEAR_LOAD;
            r_walk     <= 1'b0;
            r_dontWalk <= ~CLEAR_LOAD[0];
          end else begin
            r_count <= w_countDec;
          end
        end
        // Flash phase follows the count LSB so the last clearance cycle is always lit.
        S_CLEAR: begin
          if (bus.ped_req) begin
            r_req <= 1'b1;
          end
          if (w_countZero) begin
            r_dontWalk <= 1'b1;
            if (r_req || bus.ped_req) begin
              r_state <= S_ARMED;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_count    <= w_countDec;
            r_dontWalk <= ~w_countDec[0];
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_count    <= '0;
          r_req      <= 1'b0;
          r_walk     <= 1'b0;
          r_dontWalk <= 1'b1;
        end
      endcase
    end
  end

  assign bus.walk        = r_walk;
  assign bus.dont_walk   = r_dontWalk;
  assign bus.req_pending = r_req;
  assign bus.ped_ack     = r_ack;
  assign bus.count       = r_count;
`ifdef PEDESTRIAN_SIGNAL_CONFLICT_EN
  assign bus.conflict    = r_conflict;
`else
  assign bus.conflict    = 1'b0;
`endif

endmodule

// File: tb/tb_pedestrian_signal.sv
// Directed bench for pedestrian_signal (WALK=4, CLEAR=3): expected lamp/status vectors are queued per step
// and popped after each edge; conflict expectations follow PEDESTRIAN_SIGNAL_CONFLICT_EN.
module tb_pedestrian_signal;

  localparam int WALK_CYCLES  = 4;
  localparam int CLEAR_CYCLES = 3;
  localparam int CNT_W        = 4;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_GREEN  = 3'b101;
  localparam logic [2:0] LIGHT_YELLOW = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  typedef struct packed {
    logic             walk;
    logic             dontWalk;
    logic             pending;
    logic             ack;
    logic [CNT_W-1:0] count;
    logic             conflict;
  } expect_t;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;
  logic cf;

  expect_t expQ[$];

  pedestrian_signal_if #(.CNT_W(CNT_W)) bus ();

  pedestrian_signal #(
    .WALK_CYCLES (WALK_CYCLES),
    .CLEAR_CYCLES(CLEAR_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compareField(input string tag, input string name,
                              input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("[TB] FAIL %s.%s: observed %0h expected %0h", tag, name, got, want);
    end
  endtask

  task automatic checkOutput(input string tag);
    expect_t e;
    if (expQ.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      e = expQ.pop_front();
      compareField(tag, "walk",        CNT_W'(bus.walk),        CNT_W'(e.walk));
      compareField(tag, "dont_walk",   CNT_W'(bus.dont_walk),   CNT_W'(e.dontWalk));
      compareField(tag, "req_pending", CNT_W'(bus.req_pending), CNT_W'(e.pending));
      compareField(tag, "ped_ack",     CNT_W'(bus.ped_ack),     CNT_W'(e.ack));
      compareField(tag, "count",       bus.count,               e.count);
      compareField(tag, "conflict",    CNT_W'(bus.conflict),    CNT_W'(e.conflict));
    end
  endtask

  task automatic pushExpect(input logic w, input logic dw, input logic p, input logic a,
                            input int c, input logic cfl);
    expect_t e;
    e.walk     = w;
    e.dontWalk = dw;
    e.pending  = p;
    e.ack      = a;
    e.count    = CNT_W'(c);
    e.conflict = cfl;
    expQ.push_back(e);
  endtask

  // One directed step: drive at the falling edge, queue the expected post-edge outputs, check after the edge.
  task automatic applyStimulus(input string tag, input logic req, input logic [2:0] lt,
                               input logic w, input logic dw, input logic p, input logic a,
                               input int c, input logic cfl);
    @(negedge clk);
    bus.ped_req = req;
    bus.lights  = lt;
    pushExpect(w, dw, p, a, c, cfl);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cf          = 1'b0;
    reset_n     = 1'b0;
    bus.ped_req = 1'b1;
    bus.lights  = LIGHT_GREEN;

    for (int i = 0; i < 3; i++)
      applyStimulus("reset", 1, LIGHT_GREEN, 0, 1, 0, 0, 0, 0);
    reset_n = 1'b1;

    applyStimulus("s2_arm", 1, LIGHT_GREEN, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus("s2_hold", 0, LIGHT_GREEN, 0, 1, 1, 0, 0, 0);
    applyStimulus("s2_grant", 0, LIGHT_RED, 1, 0, 0, 1, 3, 0);
    applyStimulus("s2_walk2", 0, LIGHT_RED, 1, 0, 0, 0, 2, 0);
    applyStimulus("s2_walk1", 0, LIGHT_RED, 1, 0, 0, 0, 1, 0);
    applyStimulus("s2_walk0", 0, LIGHT_RED, 1, 0, 0, 0, 0, 0);
    applyStimulus("s2_clr2",  0, LIGHT_RED, 0, 1, 0, 0, 2, 0);
    applyStimulus("s2_clr1",  0, LIGHT_RED, 0, 0, 0, 0, 1, 0);
    applyStimulus("s2_clr0",  0, LIGHT_RED, 0, 1, 0, 0, 0, 0);
    applyStimulus("s2_idle",  0, LIGHT_RED, 0, 1, 0, 0, 0, 0);

    applyStimulus("s3_arm",   1, LIGHT_RED, 0, 1, 1, 0, 0, 0);
    applyStimulus("s3_grant", 0, LIGHT_RED, 1, 0, 0, 1, 3, 0);
    applyStimulus("s3_walk2", 0, LIGHT_RED, 1, 0, 0, 0, 2, 0);
    applyStimulus("s3_walk1", 0, LIGHT_RED, 1, 0, 0, 0, 1, 0);
    applyStimulus("s3_walk0", 0, LIGHT_RED, 1, 0, 0, 0, 0, 0);
    applyStimulus("s3_clr2",  0, LIGHT_RED, 0, 1, 0, 0, 2, 0);
    applyStimulus("s3_clr1",  0, LIGHT_RED, 0, 0, 0, 0, 1, 0);
    applyStimulus("s3_queue", 1, LIGHT_RED, 0, 1, 1, 0, 0, 0);
    applyStimulus("s3_rearm", 0, LIGHT_RED, 0, 1, 1, 0, 0, 0);
    applyStimulus("s3_regrant", 1, LIGHT_RED, 1, 0, 0, 1, 3, 0);
    applyStimulus("s3_walkreq", 1, LIGHT_RED, 1, 0, 1, 0, 2, 0);
    applyStimulus("s3_qwalk1", 0, LIGHT_RED, 1, 0, 1, 0, 1, 0);
    applyStimulus("s3_qwalk0", 0, LIGHT_RED, 1, 0, 1, 0, 0, 0);
    applyStimulus("s3_qclr2",  0, LIGHT_RED, 0, 1, 1, 0, 2, 0);
    applyStimulus("s3_qclr1",  0, LIGHT_RED, 0, 0, 1, 0, 1, 0);
    applyStimulus("s3_qclr0",  0, LIGHT_RED, 0, 1, 1, 0, 0, 0);
    applyStimulus("s3_reqexit", 0, LIGHT_RED, 0, 1, 1, 0, 0, 0);
    applyStimulus("s3_holdgrn", 0, LIGHT_GREEN, 0, 1, 1, 0, 0, 0);
    applyStimulus("s3_holdoff", 0, LIGHT_OFF, 0, 1, 1, 0, 0, 0);
    applyStimulus("s3_grant3", 0, LIGHT_RED, 1, 0, 0, 1, 3, 0);
    applyStimulus("s3_w2",    0, LIGHT_RED, 1, 0, 0, 0, 2, 0);
    applyStimulus("s3_w1",    0, LIGHT_RED, 1, 0, 0, 0, 1, 0);
    applyStimulus("s3_w0",    0, LIGHT_RED, 1, 0, 0, 0, 0, 0);
    applyStimulus("s3_c2",    0, LIGHT_RED, 0, 1, 0, 0, 2, 0);
    applyStimulus("s3_c1",    0, LIGHT_RED, 0, 0, 0, 0, 1, 0);
    applyStimulus("s3_c0",    0, LIGHT_RED, 0, 1, 0, 0, 0, 0);
    applyStimulus("s3_simul", 1, LIGHT_RED, 0, 1, 1, 0, 0, 0);

    applyStimulus("s4_grant", 0, LIGHT_RED, 1, 0, 0, 1, 3, 0);
    applyStimulus("s4_walk2", 0, LIGHT_RED, 1, 0, 0, 0, 2, 0);
`ifdef PEDESTRIAN_SIGNAL_CONFLICT_EN
    applyStimulus("s4_abort", 0, LIGHT_YELLOW, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++)
      applyStimulus("s4_sticky", 0, LIGHT_YELLOW, 0, 1, 0, 0, 0, 1);
    cf = 1'b1;
`else
    applyStimulus("s5_walk1", 0, LIGHT_YELLOW, 1, 0, 0, 0, 1, 0);
    applyStimulus("s5_walk0", 0, LIGHT_YELLOW, 1, 0, 0, 0, 0, 0);
    applyStimulus("s5_clr2",  0, LIGHT_YELLOW, 0, 1, 0, 0, 2, 0);
    applyStimulus("s5_clr1",  0, LIGHT_YELLOW, 0, 0, 0, 0, 1, 0);
    applyStimulus("s5_clr0",  0, LIGHT_YELLOW, 0, 1, 0, 0, 0, 0);
    applyStimulus("s5_idle",  0, LIGHT_YELLOW, 0, 1, 0, 0, 0, 0);
    cf = 1'b0;
`endif

    applyStimulus("s6_arm",   1, LIGHT_RED, 0, 1, 1, 0, 0, cf);
    applyStimulus("s6_grant", 0, LIGHT_RED, 1, 0, 0, 1, 3, cf);
    applyStimulus("s6_walk",  0, LIGHT_RED, 1, 0, 0, 0, 2, cf);
    #2;
    reset_n = 1'b0;
    #1;
    pushExpect(0, 1, 0, 0, 0, 0);
    checkOutput("s6_async");
    applyStimulus("s6_held",  0, LIGHT_RED, 0, 1, 0, 0, 0, 0);
    reset_n = 1'b1;
    applyStimulus("s6_idle",  0, LIGHT_RED, 0, 1, 0, 0, 0, 0);
    applyStimulus("s6_rearm", 1, LIGHT_RED, 0, 1, 1, 0, 0, 0);
    applyStimulus("s6_regrant", 0, LIGHT_RED, 1, 0, 0, 1, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
